// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared sizing helpers and operand extension for the pipelined multiplier
package mul_pkg;

    function automatic int lat(input int width);
        return width - 1;
    endfunction

    function automatic int pw(input int width);
        return 2 * width;
    endfunction

    // Sign- or zero-extends the low `width` bits of a to 64 bits; callers truncate to 2*WIDTH.
    function automatic logic [63:0] ext_operand(input logic [31:0] a, input logic sgn, input int width);
        logic [63:0] r;
        logic        msb;
        msb = sgn & a[5'(width - 1)];
        for (int i = 0; i < 64; i++) begin
            r[i] = (i < width) ? a[i[4:0]] : msb;
        end
        return r;
    endfunction

endpackage

// File: rtl/mul_pipe_stage.sv
// rtl/mul_pipe_stage.sv - one accumulation stage: adds (or, for the signed MSB row, subtracts) row K
module mul_pipe_stage
    import mul_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int K     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic [2*WIDTH-1:0]   sum_in,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    input  logic                 sgn_in,
    input  logic                 valid_in,
    output logic [2*WIDTH-1:0]   sum_out,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    output logic                 sgn_out,
    output logic                 valid_out
);

    localparam int PW = pw(WIDTH);

    logic [31:0]   a_wide;
    logic [PW-1:0] ext;
    logic [PW-1:0] row;
    logic [PW-1:0] sum_next;

    always_comb begin
        a_wide              = '0;
        a_wide[WIDTH-1:0]   = a_in;
        ext                 = PW'(ext_operand(a_wide, sgn_in, WIDTH));
        row                 = b_in[K] ? (ext << K) : '0;
        // The b MSB carries negative weight in two's complement.
        sum_next            = (sgn_in && (K == WIDTH - 1)) ? (sum_in - row) : (sum_in + row);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_out   <= '0;
            a_out     <= '0;
            b_out     <= '0;
            sgn_out   <= 1'b0;
            valid_out <= 1'b0;
        end else if (ce) begin
            sum_out   <= sum_next;
            a_out     <= a_in;
            b_out     <= b_in;
            sgn_out   <= sgn_in;
            valid_out <= valid_in;
        end
    end

endmodule

// File: rtl/mul_pipe_n.sv
// rtl/mul_pipe_n.sv - parametrised pipelined array multiplier with per-sample signed mode
module mul_pipe_n
    import mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    output logic                 out_sgn,
    output logic [2*WIDTH-1:0]   p
);

    localparam int LAT = lat(WIDTH);
    localparam int PW  = pw(WIDTH);

    logic [PW-1:0]    sum_r   [1:LAT];
    logic [WIDTH-1:0] a_r     [1:LAT];
    logic [WIDTH-1:0] b_r     [1:LAT];
    logic             sgn_r   [1:LAT];
    logic             valid_r [1:LAT];

    logic [31:0]   a_wide;
    logic [PW-1:0] row0;

    // Stage 1 folds row 0 in from the live inputs, so it is a two-row stage.
    always_comb begin
        a_wide            = '0;
        a_wide[WIDTH-1:0] = a;
        row0              = b[0] ? PW'(ext_operand(a_wide, sgn, WIDTH)) : '0;
    end

    mul_pipe_stage #(.WIDTH(WIDTH), .K(1)) u_stage1 (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .sum_in    (row0),
        .a_in      (a),
        .b_in      (b),
        .sgn_in    (sgn),
        .valid_in  (in_valid),
        .sum_out   (sum_r[1]),
        .a_out     (a_r[1]),
        .b_out     (b_r[1]),
        .sgn_out   (sgn_r[1]),
        .valid_out (valid_r[1])
    );

    for (genvar k = 2; k <= LAT; k++) begin : g_stage
        mul_pipe_stage #(.WIDTH(WIDTH), .K(k)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .ce        (ce),
            .sum_in    (sum_r[k-1]),
            .a_in      (a_r[k-1]),
            .b_in      (b_r[k-1]),
            .sgn_in    (sgn_r[k-1]),
            .valid_in  (valid_r[k-1]),
            .sum_out   (sum_r[k]),
            .a_out     (a_r[k]),
            .b_out     (b_r[k]),
            .sgn_out   (sgn_r[k]),
            .valid_out (valid_r[k])
        );
    end

    assign p         = sum_r[LAT];
    assign out_valid = valid_r[LAT];
    assign out_sgn   = sgn_r[LAT];

endmodule
